// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite address generator: FSM encoding,
// descriptor word layout, CFG bit positions and the decoded descriptor type.
// Descriptor fields are stored FIELD_W bits wide, so COORD_WIDTH and
// GLYPH_ADDR_WIDTH must not exceed FIELD_W.
package sprite_pkg;

  localparam int unsigned FIELD_W          = 16;
  localparam int unsigned SIZE_W           = 6;
  localparam int unsigned WORDS_PER_SPRITE = 5;

  // Word index within one sprite's descriptor block
  localparam logic [2:0] W_X     = 3'd0;
  localparam logic [2:0] W_Y     = 3'd1;
  localparam logic [2:0] W_FRAME = 3'd2;
  localparam logic [2:0] W_CFG   = 3'd3;
  localparam logic [2:0] W_BASE  = 3'd4;

  // CFG word fields
  localparam int unsigned CFG_EN    = 17;
  localparam int unsigned CFG_HFLIP = 16;
  localparam int unsigned CFG_W_HI  = 11;
  localparam int unsigned CFG_W_LO  = 6;
  localparam int unsigned CFG_H_HI  = 5;
  localparam int unsigned CFG_H_LO  = 0;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CALC  = 2'd2,
    ST_DRAW  = 2'd3
  } state_e;

  // Decoded sprite descriptor; wm1/hm1 are width-1 and height-1
  typedef struct packed {
    logic               en;
    logic               hflip;
    logic [SIZE_W-1:0]  wm1;
    logic [SIZE_W-1:0]  hm1;
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] frame;
    logic [FIELD_W-1:0] base;
  } sprite_desc_t;

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit test and local glyph offset (combinational).
//   desc     : decoded descriptor of this sprite
//   x_pos    : screen column, y_pos : screen row
//   hit_c    : sprite enabled and covers (x_pos, y_pos)
//   offset_c : row*width + column inside the sprite (valid only on hit)
// Optional macro SPRITE_HFLIP_EN mirrors the column when CFG hflip is set.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int unsigned COORD_WIDTH      = 10,
  parameter int unsigned GLYPH_ADDR_WIDTH = 16
) (
  input  sprite_desc_t                desc,
  input  logic [COORD_WIDTH-1:0]      x_pos,
  input  logic [COORD_WIDTH-1:0]      y_pos,
  output logic                        hit_c,
  output logic [GLYPH_ADDR_WIDTH-1:0] offset_c
);

  // One extra bit so X+width beyond the screen edge does not wrap
  localparam int unsigned EXT_W  = COORD_WIDTH + 1;
  localparam int unsigned PROD_W = COORD_WIDTH + SIZE_W + 1;

  logic [EXT_W-1:0]       px, py, sx, sy, sw, sh;
  logic [COORD_WIDTH-1:0] dx, dy, xoff;
  logic [PROD_W-1:0]      row;
  logic                   unused_desc;

  always_comb begin
    px = {1'b0, x_pos};
    py = {1'b0, y_pos};
    sx = EXT_W'(desc.x[COORD_WIDTH-1:0]);
    sy = EXT_W'(desc.y[COORD_WIDTH-1:0]);
    sw = EXT_W'(desc.wm1) + EXT_W'(1);
    sh = EXT_W'(desc.hm1) + EXT_W'(1);

    hit_c = desc.en && (px >= sx) && (px < sx + sw) &&
            (py >= sy) && (py < sy + sh);

    dx   = x_pos - desc.x[COORD_WIDTH-1:0];
    dy   = y_pos - desc.y[COORD_WIDTH-1:0];
    xoff = dx;
`ifdef SPRITE_HFLIP_EN
    if (desc.hflip) xoff = COORD_WIDTH'(desc.wm1) - dx;
`endif
    row      = PROD_W'(dy) * PROD_W'(sw);
    offset_c = GLYPH_ADDR_WIDTH'(row) + GLYPH_ADDR_WIDTH'(xoff);
  end

  // Not every descriptor field matters for the hit test
  assign unused_desc = ^desc;

endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite glyph address generator.
// Each frame: fetches NUM_SPRITES 5-word descriptors from system RAM,
// precomputes per-sprite animation frame bases with one shared multiplier,
// then per pixel registers the glyph ROM address of the lowest-index hit.
//   clk, reset      : clock, synchronous active-high reset
//   bright, vsync   : visible region flag, active-low vertical sync
//   hcount, vcount  : VGA counters
//   sys_data/addr   : system RAM read port (data one cycle after address)
//   glyph_addr      : glyph ROM address, pix_en : pixel covered,
//   sprite_id       : winning sprite, table_ready : descriptors valid
// Optional macro SPRITE_HFLIP_EN enables horizontal flip (see hit unit).
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES      = 8,
  parameter int unsigned SYS_DATA_WIDTH   = 18,
  parameter int unsigned SYS_ADDR_WIDTH   = 16,
  parameter int unsigned GLYPH_ADDR_WIDTH = 16,
  parameter logic [SYS_ADDR_WIDTH-1:0] TABLE_BASE = SYS_ADDR_WIDTH'(16'h00C8),
  parameter int unsigned H_START          = 158,
  parameter int unsigned COORD_WIDTH      = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bright,
  input  logic                        vsync,
  input  logic [9:0]                  hcount,
  input  logic [9:0]                  vcount,
  input  logic [SYS_DATA_WIDTH-1:0]   sys_data,
  output logic [SYS_ADDR_WIDTH-1:0]   sys_addr,
  output logic [GLYPH_ADDR_WIDTH-1:0] glyph_addr,
  output logic                        pix_en,
  output logic [3:0]                  sprite_id,
  output logic                        table_ready
);

  localparam int unsigned NUM_WORDS = WORDS_PER_SPRITE * NUM_SPRITES;
  localparam int unsigned KW        = $clog2(NUM_WORDS + 1);
  localparam int unsigned AREA_W    = 2 * SIZE_W + 1;
  localparam int unsigned MUL_W     = COORD_WIDTH + AREA_W;
  localparam int unsigned GW        = GLYPH_ADDR_WIDTH;

  state_e                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [3:0]                lat_spr_q, lat_spr_d;
  logic [2:0]                lat_wrd_q, lat_wrd_d;
  sprite_desc_t              desc_q [NUM_SPRITES];
  sprite_desc_t              desc_d [NUM_SPRITES];
  logic [GW-1:0]             fb_q   [NUM_SPRITES];
  logic [GW-1:0]             fb_d   [NUM_SPRITES];
  logic [SYS_ADDR_WIDTH-1:0] sys_addr_q, sys_addr_d;
  logic [GW-1:0]             glyph_addr_q, glyph_addr_d;
  logic                      pix_en_q, pix_en_d;
  logic [3:0]                sprite_id_q, sprite_id_d;
  logic                      table_ready_q, table_ready_d;

  logic [COORD_WIDTH-1:0]    x_pos_c, y_pos_c;
  logic [NUM_SPRITES-1:0]    hit_c;
  logic [GW-1:0]             off_c [NUM_SPRITES];
  logic                      any_hit_c;
  logic [3:0]                win_id_c;
  logic [GW-1:0]             win_addr_c;
  sprite_desc_t              calc_desc_c;
  logic [AREA_W-1:0]         area_c;
  logic [MUL_W-1:0]          mul_c;
  logic [GW-1:0]             calc_base_c;
  logic                      unused_calc;

  assign x_pos_c = COORD_WIDTH'(hcount) - COORD_WIDTH'(H_START);
  assign y_pos_c = COORD_WIDTH'(vcount);

  // Per-sprite hit test
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    sprite_hit_unit #(
      .COORD_WIDTH     (COORD_WIDTH),
      .GLYPH_ADDR_WIDTH(GLYPH_ADDR_WIDTH)
    ) u_hit (
      .desc    (desc_q[gi]),
      .x_pos   (x_pos_c),
      .y_pos   (y_pos_c),
      .hit_c   (hit_c[gi]),
      .offset_c(off_c[gi])
    );
  end

  // Priority encoder: descending scan so the lowest index wins
  always_comb begin
    any_hit_c  = 1'b0;
    win_id_c   = '0;
    win_addr_c = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        any_hit_c  = 1'b1;
        win_id_c   = 4'(i);
        win_addr_c = fb_q[i] + off_c[i];
      end
    end
  end

  // Shared frame-base multiplier, sprite selected by the CALC counter
  always_comb begin
    calc_desc_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (k_q == KW'(i)) calc_desc_c = desc_q[i];
    end
    area_c      = (AREA_W'(calc_desc_c.wm1) + AREA_W'(1)) *
                  (AREA_W'(calc_desc_c.hm1) + AREA_W'(1));
    mul_c       = MUL_W'(calc_desc_c.frame[COORD_WIDTH-1:0]) * MUL_W'(area_c);
    calc_base_c = calc_desc_c.base[GW-1:0] + GW'(mul_c);
  end

  assign unused_calc = ^{calc_desc_c, mul_c};

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    lat_spr_d     = lat_spr_q;
    lat_wrd_d     = lat_wrd_q;
    desc_d        = desc_q;
    fb_d          = fb_q;
    sys_addr_d    = TABLE_BASE;
    glyph_addr_d  = glyph_addr_q;
    pix_en_d      = 1'b0;
    sprite_id_d   = sprite_id_q;
    table_ready_d = table_ready_q;

    unique case (state_q)
      ST_WAIT: begin
        if (vsync) begin
          state_d   = ST_FETCH;
          k_d       = '0;
          lat_spr_d = '0;
          lat_wrd_d = W_X;
        end
      end
      ST_FETCH: begin
        // Data for address k-1 is on sys_data this cycle
        if (k_q != '0) begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            if (lat_spr_q == 4'(i)) begin
              case (lat_wrd_q)
                W_X:     desc_d[i].x     = FIELD_W'(sys_data[COORD_WIDTH-1:0]);
                W_Y:     desc_d[i].y     = FIELD_W'(sys_data[COORD_WIDTH-1:0]);
                W_FRAME: desc_d[i].frame = FIELD_W'(sys_data[COORD_WIDTH-1:0]);
                W_CFG: begin
                  desc_d[i].en    = sys_data[CFG_EN];
                  desc_d[i].hflip = sys_data[CFG_HFLIP];
                  desc_d[i].wm1   = sys_data[CFG_W_HI:CFG_W_LO];
                  desc_d[i].hm1   = sys_data[CFG_H_HI:CFG_H_LO];
                end
                W_BASE:  desc_d[i].base  = FIELD_W'(sys_data[GW-1:0]);
                default: ;
              endcase
            end
          end
          if (lat_wrd_q == W_BASE) begin
            lat_wrd_d = W_X;
            lat_spr_d = lat_spr_q + 4'd1;
          end else begin
            lat_wrd_d = lat_wrd_q + 3'd1;
          end
        end
        if (k_q == KW'(NUM_WORDS)) begin
          state_d = ST_CALC;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_CALC: begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (k_q == KW'(i)) fb_d[i] = calc_base_c;
        end
        if (k_q == KW'(NUM_SPRITES - 1)) begin
          state_d       = ST_DRAW;
          k_d           = '0;
          table_ready_d = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DRAW: begin
        if (bright && any_hit_c) begin
          pix_en_d     = 1'b1;
          glyph_addr_d = win_addr_c;
          sprite_id_d  = win_id_c;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Vertical sync aborts everything; descriptors are retained
    if (!vsync) begin
      state_d       = ST_WAIT;
      k_d           = '0;
      lat_spr_d     = '0;
      lat_wrd_d     = W_X;
      table_ready_d = 1'b0;
    end

    if (state_d == ST_FETCH && k_d < KW'(NUM_WORDS)) begin
      sys_addr_d = TABLE_BASE + SYS_ADDR_WIDTH'(k_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      k_q           <= '0;
      lat_spr_q     <= '0;
      lat_wrd_q     <= W_X;
      sys_addr_q    <= TABLE_BASE;
      glyph_addr_q  <= '0;
      pix_en_q      <= 1'b0;
      sprite_id_q   <= '0;
      table_ready_q <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        desc_q[i] <= '0;
        fb_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      lat_spr_q     <= lat_spr_d;
      lat_wrd_q     <= lat_wrd_d;
      sys_addr_q    <= sys_addr_d;
      glyph_addr_q  <= glyph_addr_d;
      pix_en_q      <= pix_en_d;
      sprite_id_q   <= sprite_id_d;
      table_ready_q <= table_ready_d;
      desc_q        <= desc_d;
      fb_q          <= fb_d;
    end
  end

  assign sys_addr    = sys_addr_q;
  assign glyph_addr  = glyph_addr_q;
  assign pix_en      = pix_en_q;
  assign sprite_id   = sprite_id_q;
  assign table_ready = table_ready_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen with two sprite slots.
module tb_sprite_addr_gen;

  localparam int K_ADDR  = 0;
  localparam int K_RDY   = 1;
  localparam int K_PIX   = 2;
  localparam int K_NOPIX = 3;
  localparam int BASE_A  = 200;  // 16'h00C8

  typedef struct {
    int kind;
    int v;
    int id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, bright, vsync;
  logic [9:0]  hcount, vcount;
  logic [17:0] sys_data;
  logic [15:0] sys_addr, glyph_addr;
  logic        pix_en, table_ready;
  logic [3:0]  sprite_id;

  logic [17:0] mem [256];
  exp_t        exp_q [$];
  exp_t        e;
  int          acc = 0, n_probe = 0, n_probe_d = 0;
  int          total = 0, bad = 0;
  bit          done = 1'b0;

  sprite_addr_gen #(.NUM_SPRITES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bright     (bright),
    .vsync      (vsync),
    .hcount     (hcount),
    .vcount     (vcount),
    .sys_data   (sys_data),
    .sys_addr   (sys_addr),
    .glyph_addr (glyph_addr),
    .pix_en     (pix_en),
    .sprite_id  (sprite_id),
    .table_ready(table_ready)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data one cycle after address
  always @(posedge clk) sys_data <= mem[sys_addr[7:0]];

  always @(posedge clk) n_probe_d <= n_probe;

  task automatic chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: pops one record per expectation due after the last edge
  always @(negedge clk) begin
    for (int i = 0; i < n_probe_d; i++) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: got empty queue expected a record");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_ADDR: chk("sys_addr", int'(sys_addr), e.v);
          K_RDY:  chk("table_ready", int'(table_ready), e.v);
          K_PIX: begin
            chk("pix_en_hit", int'(pix_en), 1);
            chk("glyph_addr", int'(glyph_addr), e.v);
            chk("sprite_id", int'(sprite_id), e.id);
          end
          default: begin
            chk("pix_en_miss", int'(pix_en), 0);
            chk("glyph_hold", int'(glyph_addr), e.v);
            chk("sprite_id_hold", int'(sprite_id), e.id);
          end
        endcase
      end
    end
    if (done) begin
      chk("leftover_expectations", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic expect_nx(int kind, int v, int id);
    exp_t r;
    r.kind = kind;
    r.v    = v;
    r.id   = id;
    exp_q.push_back(r);
    acc++;
  endtask

  task automatic tick();
    n_probe = acc;
    acc     = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [17:0] cfg(bit en, bit hf, int w, int h);
    return {en, hf, 4'b0000, 6'(w - 1), 6'(h - 1)};
  endfunction

  task automatic set_spr(int i, int x, int y, int fr, logic [17:0] c, int base);
    mem[BASE_A + 5*i + 0] = 18'(x);
    mem[BASE_A + 5*i + 1] = 18'(y);
    mem[BASE_A + 5*i + 2] = 18'(fr);
    mem[BASE_A + 5*i + 3] = c;
    mem[BASE_A + 5*i + 4] = 18'(base);
  endtask

  task automatic vsync_low();
    vsync  = 1'b0;
    bright = 1'b0;
    expect_nx(K_ADDR, BASE_A, 0);
    expect_nx(K_RDY, 0, 0);
    tick();
    tick();
  endtask

  // Edge j after vsync rises: j=0..9 address steps, j=13 table_ready
  task automatic fetch_frame(bit chk_seq);
    vsync  = 1'b1;
    bright = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (chk_seq) begin
        if (j <= 9)  expect_nx(K_ADDR, BASE_A + j, 0);
        if (j == 10) expect_nx(K_ADDR, BASE_A, 0);
        if (j == 12) expect_nx(K_RDY, 0, 0);
      end
      if (j == 13) expect_nx(K_RDY, 1, 0);
      tick();
    end
  endtask

  task automatic pix(int h, int v, bit b, int kind, int g, int id);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = b;
    expect_nx(kind, g, id);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset  = 1'b1;
    vsync  = 1'b0;
    bright = 1'b0;
    hcount = '0;
    vcount = '0;
    @(negedge clk);
    tick();
    expect_nx(K_ADDR, BASE_A, 0);
    expect_nx(K_RDY, 0, 0);
    expect_nx(K_NOPIX, 0, 0);
    tick();
    reset = 1'b0;
    tick();

    // Frame A: 32x32 sprite and a sprite straddling the right edge
    set_spr(0, 100, 50, 2, cfg(1, 0, 32, 32), 0);
    set_spr(1, 1020, 0, 0, cfg(1, 0, 8, 4), 3000);
    fetch_frame(1);
    pix(258, 60, 1, K_PIX,   2368, 0);
    pix(289, 81, 1, K_PIX,   3071, 0);
    pix(290, 60, 1, K_NOPIX, 3071, 0);
    pix(160, 1,  1, K_NOPIX, 3071, 0);
    pix(157, 1,  1, K_PIX,   3011, 1);
    pix(153, 1,  1, K_NOPIX, 3011, 1);
    pix(258, 60, 0, K_NOPIX, 3011, 1);
    pix(157, 3,  1, K_PIX,   3027, 1);
    pix(157, 4,  1, K_NOPIX, 3027, 1);

    // Frame B: overlapping sprites, fetch aborted at k=4 first
    vsync_low();
    set_spr(0, 0, 0, 0, cfg(1, 0, 16, 16), 0);
    set_spr(1, 8, 8, 1, cfg(1, 0, 8, 8), 500);
    vsync = 1'b1;
    for (int j = 0; j < 5; j++) begin
      expect_nx(K_ADDR, BASE_A + j, 0);
      tick();
    end
    vsync = 1'b0;
    expect_nx(K_ADDR, BASE_A, 0);
    expect_nx(K_RDY, 0, 0);
    tick();
    tick();
    fetch_frame(1);
    pix(168, 10, 1, K_PIX,   170, 0);
    pix(174, 12, 1, K_NOPIX, 170, 0);

    // Sprite 0 disabled: sprite 1 now wins at (10,10)
    vsync_low();
    mem[BASE_A + 3] = cfg(0, 0, 16, 16);
    fetch_frame(0);
    pix(168, 10, 1, K_PIX, 582, 1);

    // Frame C: 1x1 sprite and an hflip sprite of width 18
    vsync_low();
    set_spr(0, 500, 200, 3, cfg(1, 0, 1, 1), 10);
    set_spr(1, 600, 300, 0, cfg(1, 1, 18, 2), 4000);
    fetch_frame(0);
    pix(658, 200, 1, K_PIX,   13, 0);
    pix(659, 200, 1, K_NOPIX, 13, 0);
    pix(658, 201, 1, K_NOPIX, 13, 0);
    pix(657, 200, 1, K_NOPIX, 13, 0);
`ifdef SPRITE_HFLIP_EN
    pix(758, 300, 1, K_PIX, 4017, 1);
    pix(775, 300, 1, K_PIX, 4000, 1);
`else
    pix(758, 300, 1, K_PIX, 4000, 1);
    pix(775, 300, 1, K_PIX, 4017, 1);
`endif
    tick();
    done = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL watchdog: got no summary expected monitor to finish");
    $fatal(1);
  end

endmodule
